// File: rtl/jtkicker_irq_pkg.sv
// rtl/jtkicker_irq_pkg.sv - register map shared by the interrupt controller and its users
package jtkicker_irq_pkg;

   localparam logic [1:0] REG_EN   = 2'd0;
   localparam logic [1:0] REG_POL  = 2'd1;
   localparam logic [1:0] REG_ACK  = 2'd2;
   localparam logic [1:0] REG_WDOG = 2'd3;

endpackage

// File: rtl/jtkicker_irqctl_ch.sv
// rtl/jtkicker_irqctl_ch.sv - one interrupt channel: trigger edge detect and pending flop
module jtkicker_irqctl_ch (
   input  logic clk,
   input  logic rstn,
   input  logic armed,
   input  logic trig,
   input  logic pol,
   input  logic en,
   input  logic pause,
   input  logic ack,
   output logic pending,
   output logic rise
);

   logic trig_l;
   logic edge_det;

   // armed masks the first clk after reset so a source already high is not an edge
   always_comb begin
      rise     = armed & ~trig_l & trig;
      edge_det = armed & (pol ? (trig_l & ~trig) : (~trig_l & trig));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         trig_l  <= 1'b0;
         pending <= 1'b0;
      end else begin
         trig_l <= trig;
         if (!en)
            pending <= 1'b0;
         else if (edge_det && !pause)
            pending <= 1'b1;
         else if (ack)
            pending <= 1'b0;
      end
   end

endmodule

// File: rtl/jtkicker_irqctl.sv
// rtl/jtkicker_irqctl.sv - multi-channel edge-triggered IRQ controller; watchdog gated by JTKICKER_WDOG_EN
module jtkicker_irqctl
   import jtkicker_irq_pkg::*;
#(
   parameter int NCH         = 2,
   parameter int WDOG_FRAMES = 8
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           cen,
   input  logic           cs,
   input  logic           wr,
   input  logic [1:0]     addr,
   input  logic [7:0]     din,
   output logic [7:0]     dout,
   input  logic [NCH-1:0] trig,
   input  logic           pause,
   output logic [NCH-1:0] irq_n,
   output logic           wdog_rst
);

   logic           armed;
   logic           bus_wr;
   logic           kick;
   logic [NCH-1:0] en, en_nx, pol, ack, pending, rise;
   logic [7:0]     wdog_cnt;
   logic [7:0]     rd_data;

   assign bus_wr = cs & wr & cen;
   assign kick   = bus_wr && (addr == REG_WDOG);
   assign ack    = (bus_wr && (addr == REG_ACK)) ? din[NCH-1:0] : '0;
   // channels see the enable being written this clk so a disable beats a same-clk edge
   assign en_nx  = (bus_wr && (addr == REG_EN)) ? din[NCH-1:0] : en;
   assign irq_n  = ~pending;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         armed <= 1'b0;
         en    <= '0;
         pol   <= '0;
      end else begin
         armed <= 1'b1;
         en    <= en_nx;
         if (bus_wr && (addr == REG_POL))
            pol <= din[NCH-1:0];
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      jtkicker_irqctl_ch u_ch (
         .clk     (clk),
         .rstn    (rstn),
         .armed   (armed),
         .trig    (trig[i]),
         .pol     (pol[i]),
         .en      (en_nx[i]),
         .pause   (pause),
         .ack     (ack[i]),
         .pending (pending[i]),
         .rise    (rise[i])
      );
   end

`ifdef JTKICKER_WDOG_EN
   localparam logic [7:0] WDOG_LAST = 8'(WDOG_FRAMES - 1);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wdog_cnt <= 8'd0;
         wdog_rst <= 1'b0;
      end else begin
         wdog_rst <= 1'b0;
         if (kick) begin
            wdog_cnt <= 8'd0;
         end else if (rise[0]) begin
            if (wdog_cnt == WDOG_LAST) begin
               wdog_cnt <= 8'd0;
               wdog_rst <= 1'b1;
            end else begin
               wdog_cnt <= wdog_cnt + 8'd1;
            end
         end
      end
   end
`else
   assign wdog_cnt = 8'd0;
   assign wdog_rst = 1'b0;
`endif

   always_comb begin
      rd_data = 8'd0;
      case (addr)
         REG_EN:  rd_data = 8'(en);
         REG_POL: rd_data = 8'(pol);
         REG_ACK: rd_data = 8'(pending);
         default: rd_data = wdog_cnt;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         dout <= 8'd0;
      else if (cs && !wr)
         dout <= rd_data;
   end

   logic unused_in;
   assign unused_in = ^{din, rise, kick};

endmodule

// File: tb/tb_jtkicker_irqctl.sv
// tb/tb_jtkicker_irqctl.sv - directed self-checking bench for jtkicker_irqctl
module tb_jtkicker_irqctl;

   logic       clk = 1'b0;
   logic       rstn, cen, cs, wr, pause;
   logic [1:0] addr;
   logic [7:0] din, dout, dout8, rd, rd8;
   logic [1:0] trig, irq_n;
   logic [7:0] trig8, irq_n8;
   logic       wdog_rst, wdog_rst8;
   int         total = 0;
   int         bad = 0;
   int         pulses;
   logic       pulse_at_4th;

   always #5 clk = ~clk;

   jtkicker_irqctl #(.NCH(2), .WDOG_FRAMES(4)) dut (
      .clk(clk), .rstn(rstn), .cen(cen), .cs(cs), .wr(wr), .addr(addr), .din(din),
      .dout(dout), .trig(trig), .pause(pause), .irq_n(irq_n), .wdog_rst(wdog_rst)
   );

   jtkicker_irqctl #(.NCH(8)) dut8 (
      .clk(clk), .rstn(rstn), .cen(cen), .cs(cs), .wr(wr), .addr(addr), .din(din),
      .dout(dout8), .trig(trig8), .pause(pause), .irq_n(irq_n8), .wdog_rst(wdog_rst8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
      cs = 1'b1; wr = 1'b1; cen = 1'b1; addr = a; din = d;
      tick();
      cs = 1'b0; wr = 1'b0;
   endtask

   task automatic rd_reg(input logic [1:0] a, output logic [7:0] d, output logic [7:0] d8);
      cs = 1'b1; wr = 1'b0; addr = a;
      tick();
      d = dout; d8 = dout8;
      cs = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0; cen = 1'b1; cs = 1'b0; wr = 1'b0; pause = 1'b0;
      addr = 2'd0; din = 8'd0; trig = 2'b01; trig8 = 8'd0;
      #1;
      total++; if (irq_n !== 2'b11) begin bad++; $display("FAIL reset_irq_n got=%b exp=11", irq_n); end
      total++; if (dout !== 8'd0) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
      total++; if (wdog_rst !== 1'b0) begin bad++; $display("FAIL reset_wdog got=%b exp=0", wdog_rst); end
      total++; if (irq_n8 !== 8'hFF) begin bad++; $display("FAIL reset_irq_n8 got=%h exp=ff", irq_n8); end
      tick(); tick();
      rstn = 1'b1;
      tick(); tick();
      rd_reg(2'd3, rd, rd8);
      total++; if (rd !== 8'd0) begin bad++; $display("FAIL release_wdog_cnt got=%h exp=00", rd); end
      wr_reg(2'd0, 8'h03);
      rd_reg(2'd2, rd, rd8);
      total++; if (rd !== 8'd0) begin bad++; $display("FAIL release_trig_high got=%h exp=00", rd); end
   endtask

   task automatic test_basic();
      trig = 2'b00; tick();
      wr_reg(2'd1, 8'h00);
      trig = 2'b01;
      #0;
      total++; if (irq_n !== 2'b11) begin bad++; $display("FAIL basic_no_comb got=%b exp=11", irq_n); end
      tick();
      total++; if (irq_n !== 2'b10) begin bad++; $display("FAIL basic_rise got=%b exp=10", irq_n); end
      wr_reg(2'd2, 8'h01);
      total++; if (irq_n !== 2'b11) begin bad++; $display("FAIL basic_ack got=%b exp=11", irq_n); end
      rd_reg(2'd0, rd, rd8);
      total++; if (rd !== 8'h03) begin bad++; $display("FAIL basic_en_read got=%h exp=03", rd); end
      cen = 1'b0; cs = 1'b1; wr = 1'b1; addr = 2'd0; din = 8'h00;
      tick();
      cs = 1'b0; wr = 1'b0; cen = 1'b1;
      rd_reg(2'd0, rd, rd8);
      total++; if (rd !== 8'h03) begin bad++; $display("FAIL cen_gate got=%h exp=03", rd); end
   endtask

   task automatic test_polarity();
      wr_reg(2'd1, 8'h02);
      trig = 2'b11; tick();
      total++; if (irq_n !== 2'b11) begin bad++; $display("FAIL pol_rise_ignored got=%b exp=11", irq_n); end
      trig = 2'b01; tick();
      total++; if (irq_n !== 2'b01) begin bad++; $display("FAIL pol_fall got=%b exp=01", irq_n); end
      rd_reg(2'd2, rd, rd8);
      total++; if (rd !== 8'h02) begin bad++; $display("FAIL pol_pending got=%h exp=02", rd); end
      wr_reg(2'd2, 8'h02);
      wr_reg(2'd1, 8'h03);
      rd_reg(2'd2, rd, rd8);
      total++; if (rd !== 8'h00) begin bad++; $display("FAIL pol_toggle_static got=%h exp=00", rd); end
      wr_reg(2'd1, 8'h00);
      rd_reg(2'd2, rd, rd8);
      total++; if (rd !== 8'h00) begin bad++; $display("FAIL pol_restore_static got=%h exp=00", rd); end
   endtask

   task automatic test_same_clk();
      trig = 2'b00; tick();
      cs = 1'b1; wr = 1'b1; cen = 1'b1; addr = 2'd2; din = 8'h01; trig = 2'b01;
      tick();
      cs = 1'b0; wr = 1'b0;
      total++; if (irq_n !== 2'b10) begin bad++; $display("FAIL ack_vs_edge got=%b exp=10", irq_n); end
      wr_reg(2'd2, 8'h01);
      trig = 2'b00; tick();
      cs = 1'b1; wr = 1'b1; addr = 2'd0; din = 8'h00; trig = 2'b01;
      tick();
      cs = 1'b0; wr = 1'b0;
      total++; if (irq_n !== 2'b11) begin bad++; $display("FAIL dis_vs_edge got=%b exp=11", irq_n); end
      rd_reg(2'd2, rd, rd8);
      total++; if (rd !== 8'h00) begin bad++; $display("FAIL dis_vs_edge_pend got=%h exp=00", rd); end
      wr_reg(2'd0, 8'h03);
      trig = 2'b00; tick();
   endtask

   task automatic test_pause();
      pause = 1'b1; trig = 2'b01; tick();
      total++; if (irq_n !== 2'b11) begin bad++; $display("FAIL pause_edge got=%b exp=11", irq_n); end
      pause = 1'b0; tick(); tick();
      total++; if (irq_n !== 2'b11) begin bad++; $display("FAIL pause_level got=%b exp=11", irq_n); end
      trig = 2'b00; tick();
      trig = 2'b01; tick();
      total++; if (irq_n !== 2'b10) begin bad++; $display("FAIL pause_next_edge got=%b exp=10", irq_n); end
      wr_reg(2'd2, 8'h03);
      trig = 2'b00; tick();
   endtask

   task automatic test_wdog();
      wr_reg(2'd3, 8'h00);
      pulses = 0; pulse_at_4th = 1'b0;
      for (int r = 0; r < 4; r++) begin
         trig = 2'b01; tick();
         if (wdog_rst === 1'b1) begin pulses++; if (r == 3) pulse_at_4th = 1'b1; end
         trig = 2'b00; tick();
         if (wdog_rst === 1'b1) pulses++;
      end
`ifdef JTKICKER_WDOG_EN
      total++; if (pulses !== 1) begin bad++; $display("FAIL wdog_pulse_count got=%0d exp=1", pulses); end
      total++; if (pulse_at_4th !== 1'b1) begin bad++; $display("FAIL wdog_pulse_time got=%b exp=1", pulse_at_4th); end
      rd_reg(2'd3, rd, rd8);
      total++; if (rd !== 8'd0) begin bad++; $display("FAIL wdog_wrap got=%h exp=00", rd); end
      pulses = 0;
      for (int r = 0; r < 3; r++) begin
         trig = 2'b01; tick();
         if (wdog_rst === 1'b1) pulses++;
         trig = 2'b00; tick();
      end
      rd_reg(2'd3, rd, rd8);
      total++; if (rd !== 8'd3) begin bad++; $display("FAIL wdog_count3 got=%h exp=03", rd); end
      wr_reg(2'd3, 8'h00);
      rd_reg(2'd3, rd, rd8);
      total++; if (rd !== 8'd0) begin bad++; $display("FAIL wdog_kick got=%h exp=00", rd); end
      trig = 2'b01; tick();
      if (wdog_rst === 1'b1) pulses++;
      trig = 2'b00; tick();
      total++; if (pulses !== 0) begin bad++; $display("FAIL wdog_kicked_pulse got=%0d exp=0", pulses); end
`else
      total++; if (pulses !== 0) begin bad++; $display("FAIL wdog_off_pulse got=%0d exp=0", pulses); end
      wr_reg(2'd3, 8'h55);
      rd_reg(2'd3, rd, rd8);
      total++; if (rd !== 8'd0) begin bad++; $display("FAIL wdog_off_read got=%h exp=00", rd); end
`endif
      wr_reg(2'd2, 8'h03);
   endtask

   task automatic test_nch8();
      wr_reg(2'd0, 8'hA5);
      rd_reg(2'd0, rd, rd8);
      total++; if (rd8 !== 8'hA5) begin bad++; $display("FAIL nch8_en got=%h exp=a5", rd8); end
      total++; if (rd !== 8'h01) begin bad++; $display("FAIL nch2_en_upper got=%h exp=01", rd); end
      wr_reg(2'd0, 8'h03);
   endtask

   task automatic test_reset_mid();
      trig = 2'b00; tick();
      trig = 2'b11; tick();
      total++; if (irq_n !== 2'b00) begin bad++; $display("FAIL mid_both got=%b exp=00", irq_n); end
      rd_reg(2'd2, rd, rd8);
      total++; if (rd !== 8'h03) begin bad++; $display("FAIL mid_pending got=%h exp=03", rd); end
      #2;
      rstn = 1'b0;
      #1;
      total++; if (irq_n !== 2'b11) begin bad++; $display("FAIL mid_async_irq got=%b exp=11", irq_n); end
      total++; if (dout !== 8'd0) begin bad++; $display("FAIL mid_async_dout got=%h exp=00", dout); end
      tick();
      rstn = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_polarity();
      test_same_clk();
      test_pause();
      test_wdog();
      test_nch8();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jtkicker_irqctl.md
JTKICKER_IRQCTL -- requirements
Module: jtkicker_irqctl

Interface
REQ-001 SHALL have parameter NCH, default 2, number of interrupt channels, legal range 1..8.
REQ-002 SHALL have parameter WDOG_FRAMES, default 8, channel-0 trigger edges allowed between watchdog kicks, legal range 1..255.
REQ-003 SHALL have port clk  in  1  system clock (24 MHz); the block uses one clock only.
REQ-004 SHALL have port rstn  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port cen  in  1  CPU bus clock enable (cpu_cen).
REQ-006 SHALL have port cs  in  1  register-block chip select.
REQ-007 SHALL have port wr  in  1  write strobe, active high; read when low.
REQ-008 SHALL have port addr  in  2  register select.
REQ-009 SHALL have port din  in  8  CPU write data.
REQ-010 SHALL have port dout  out  8  registered read data.
REQ-011 SHALL have port trig  in  NCH  raw interrupt sources (LVBL, V16, ...), synchronous to clk.
REQ-012 SHALL have port pause  in  1  when high, no new pending bits are latched.
REQ-013 SHALL have port irq_n  out  NCH  per-channel active-low request, equal to ~pending.
REQ-014 SHALL have port wdog_rst  out  1  watchdog expiry pulse.

Function
REQ-015 SHALL sample trig every clk (not cen) into trig_l; edge[i] = pol[i] ? (trig_l[i] & ~trig[i]) : (~trig_l[i] & trig[i]).
REQ-016 SHALL set pending[i] on the clk edge where edge[i] & en[i] & ~pause is true, so irq_n[i] falls one clk after trig[i] is first sampled at its new level.
REQ-017 SHALL hold pending[i] at 0 while en[i]=0; disable has priority over a new edge in the same clk.
REQ-018 SHALL clear pending[i] on a write-1 to the ACK register; a new edge in the same clk wins and pending stays 1.
REQ-019 SHALL derive edges from raw trig, so a polarity change alone never creates a pending bit.
REQ-020 SHALL accept writes only when cs & wr & cen, in the same clk.
REQ-021 SHALL decode addr: 0 = EN (RW); 1 = POL (RW); 2 = ACK (W1C) / PENDING (R); 3 = WDOG (write = kick, read = count).
REQ-022 SHALL register dout on every clk with cs & ~wr; bits at NCH and above read 0; dout holds otherwise.
REQ-023 SHALL keep irq_n registered with no combinational path from trig.

Reset
REQ-024 SHALL, while rstn=0, force en, pol, pending and trig_l to 0, irq_n to all ones, dout to 0, the watchdog count to 0 and wdog_rst to 0.
REQ-025 SHALL treat trig high at reset release as already seen: trig_l loads trig on the first clk after release, with no pending bit set.
REQ-026 SHALL have reset asserted mid-interrupt clear pending immediately and asynchronously.

Configuration
REQ-027 SHALL gate the watchdog with macro JTKICKER_WDOG_EN.
REQ-028 SHALL, with JTKICKER_WDOG_EN defined:
- an 8-bit counter increments on each rising trig[0] edge, regardless of en, pol and pause;
- a WDOG write clears the counter; a kick in the same clk as an edge leaves it at 0;
- on reaching WDOG_FRAMES the counter drives wdog_rst high for exactly one clk and returns to 0.
REQ-029 SHALL, without JTKICKER_WDOG_EN, have no counter logic; wdog_rst ties to 0, WDOG reads return 0 and WDOG writes are ignored.

Structure
REQ-030 SHALL place register address constants (REG_EN=0, REG_POL=1, REG_ACK=2, REG_WDOG=3) in shared package jtkicker_irq_pkg.
REQ-031 SHALL implement per-channel edge detection and pending flop in sub-module jtkicker_irqctl_ch, instantiated NCH times by generate.

Verification
REQ-032 SHALL cover: en=0x3, pol=0, trig[0] rises -> irq_n=2'b10 one clk later; ACK write 0x1 -> irq_n=2'b11.
REQ-033 SHALL cover: pol=0x2, trig[1] falls -> pending=0x2; POL toggled with trig static -> pending unchanged.
REQ-034 SHALL cover: ACK write 0x1 in the same clk as a trig[0] edge -> pending[0] stays 1; EN write 0x0 in the same clk as an edge -> pending stays 0.
REQ-035 SHALL cover: pause=1 with a trig edge -> pending=0; pause=0 with trig already high -> still 0 until the next edge.
REQ-036 SHALL cover, with JTKICKER_WDOG_EN: WDOG_FRAMES=4, four trig[0] rises without kick -> a single 1-clk wdog_rst; a kick after three rises -> no pulse, WDOG reads 0.
REQ-037 SHALL cover: rstn low while pending=0x3 -> irq_n=2'b11 immediately; NCH=8 build reads EN back as full 8 bits.
